gpu_blit_queue: RTL and testbench
=================================

// Module: gpu_blit_queue
// PURPOSE
//  Command queue and sequencer that sits in front of the GPU blitter. The CPU pushes
//  complete fill/copy rectangles into a FIFO over a Wishbone slave port. A Wishbone
//  master then replays each entry into the blitter's register file (X, Y, W, H,
//  PATTERN, then CTRL with START) and waits for the blitter's busy flag to drop.
//  This lets the CPU queue glyph and rect draws without polling the blitter.
// PARAMETERS
//  DEPTH      4            FIFO entries; power of two, 2..16
//  BLIT_BASE  32'h0300_0000 blitter slave base; master adr = {BLIT_BASE[31:4], idx[3:0]}
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset; synchronous, active-high
//  s_cyc_i/s_stb_i/s_we_i  in 1  Wishbone slave cycle/strobe/write
//  s_sel_i    in   4   byte selects; ignored, full-word access only
//  s_adr_i    in   32  register index in s_adr_i[3:0]
//  s_dat_i    in   32  write data
//  s_ack_o    out  1   slave ack
//  s_dat_o    out  32  read data
//  m_cyc_o/m_stb_o/m_we_o  out 1  master to blitter slave; m_we_o is always 1 when active
//  m_sel_o    out  4   always 4'b1111 when active
//  m_adr_o    out  32  blitter register address
//  m_dat_o    out  32  blitter register data
//  m_ack_i    in   1   blitter ack
//  blit_busy  in   1   blitter busy output
//  busy       out  1   1 when FIFO is non-empty or the sequencer is not in S_IDLE
//  irq        out  1   drain interrupt; only with GPU_BLITQ_IRQ_EN, else tied 0
// BEHAVIOUR
//  Reset: every output is 0; FIFO empty; staging registers 0; overflow=0; state S_IDLE.
//  Slave: registered ack, 1 cycle after cyc&stb&!ack, single-cycle pulse; never stalls.
//   idx0 STATUS  R: {16'h0, count[7:0], 4'h0, irq, ovf, full, empty}
//                W: any write clears ovf and irq
//   idx1 ENGINE  R: {29'h0, state_is_idle, blit_busy, busy}
//   idx2..6      R/W staging X, Y, W, H, PATTERN
//   idx7 PUSH    W: enqueue {staging, fill=d[1], clip=d[2]}; staging keeps its values
//                R: 0
//   idx8 FLUSH   W: discard queued (not yet started) entries; the in-flight command
//                completes
//   other idx    R: 0; W: ignored
//  PUSH while full: entry is dropped and ovf is set (sticky). PUSH and FLUSH are separate
//   registers, so they never occur in the same cycle. A PUSH in the same cycle as a
//   sequencer pop is accepted even when full.
//  Sequencer FSM:
//   S_IDLE     FIFO non-empty & !blit_busy -> pop head into the cur_* regs;
//              set widx=2; go to S_WRITE.
//   S_WRITE    drive cyc=stb=we=1, sel=F, adr idx=widx, dat=cur[widx]
//              (widx 0: {29'h0, clip, fill, 1'b1}); go to S_ACK.
//   S_ACK      hold outputs until m_ack_i; on ack drop cyc/stb the next cycle.
//              widx 2..5 -> widx+1, go to S_WRITE
//              widx 6    -> widx=0,  go to S_WRITE
//              widx 0    -> go to S_DONE
//   S_DONE     wait for blit_busy==0, then go to S_IDLE.
//  Master handshake: classic single-transfer; no bus timeout.
//  Command issue cost: 6 writes x >=2 cycles, plus 1 idle gap between commands.
//  FIFO: ring buffer, rd/wr pointers of log2(DEPTH) bits that wrap naturally;
//   count is log2(DEPTH)+1 bits, zero-extended into STATUS.
//  Reset mid-transfer: master lines drop on the next edge and the queue is lost.
//   The blitter may still be running; the sequencer waits on blit_busy before its
//   next issue.
// CONFIGURATION
//  GPU_BLITQ_IRQ_EN defined: irq is set when a command completes in S_DONE and the FIFO
//   is empty. It stays high until a STATUS write or rst.
//  GPU_BLITQ_IRQ_EN undefined: irq is tied 0, the STATUS irq bit reads 0, and no irq
//   logic is built.
// TESTING
//  1 reset -> all outputs 0; STATUS reads 32'h0000_0001 (empty).
//  2 stage X=8, Y=16, W=64, H=2, PAT=FFFF_FFFF; PUSH 32'h6 -> master writes idx
//    2,3,4,5,6 with those values, then idx0 32'h7; busy falls after blit_busy falls.
//  3 hold blit_busy=1 and PUSH 5 entries (DEPTH=4) -> STATUS count=4, full=1, ovf=1,
//    no master activity; release blit_busy -> exactly 4 commands issued, in order.
//  4 queue 3 entries and FLUSH during the first command's writes -> that command
//    finishes all 6 writes; the other 2 are never issued; empty=1.
//  5 m_ack_i delayed 5 cycles per write -> stb held steady, no duplicate or skipped idx.
//  6 GPU_BLITQ_IRQ_EN: 2 queued commands -> irq rises only after the 2nd completes;
//    a STATUS write clears it; without the macro irq stays 0 throughout.

Source files
------------

// File: rtl/gpu_blit_queue.sv
// gpu_blit_queue: CPU-facing command FIFO that replays fill/copy rectangles into
// the blitter register file over a Wishbone master, one command at a time.
// Optional feature macro: GPU_BLITQ_IRQ_EN (drain interrupt); undefined -> irq tied 0.
module gpu_blit_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BLIT_BASE = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic        s_ack_o,
    output logic [31:0] s_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic        blit_busy,
    output logic        busy,
    output logic        irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic        clip;
        logic        fill;
        logic [31:0] pat;
        logic [31:0] h;
        logic [31:0] w;
        logic [31:0] y;
        logic [31:0] x;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Registers
    cmd_t          r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [31:0]   r_stg_x;
    logic [31:0]   r_stg_y;
    logic [31:0]   r_stg_w;
    logic [31:0]   r_stg_h;
    logic [31:0]   r_stg_pat;
    cmd_t          r_cur;
    logic [2:0]    r_widx;
    state_t        r_state;
    logic          r_s_ack;
    logic [31:0]   r_s_dat;
    logic          r_m_cyc;
    logic          r_m_stb;
    logic          r_m_we;
    logic [3:0]    r_m_sel;
    logic [31:0]   r_m_adr;
    logic [31:0]   r_m_dat;
    logic          r_busy;

    // Combinational
    logic          w_req;
    logic          w_wr;
    logic          w_rd;
    logic [3:0]    w_idx;
    logic          w_push;
    logic          w_flush;
    logic          w_stat_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wdata;
    state_t        w_state_nxt;
    logic [2:0]    w_widx_nxt;
    logic          w_m_cyc_nxt;
    logic          w_m_stb_nxt;
    logic          w_m_we_nxt;
    logic [3:0]    w_m_sel_nxt;
    logic [31:0]   w_m_adr_nxt;
    logic [31:0]   w_m_dat_nxt;
    logic          w_unused_ok;

    // Only full-word accesses and the low register index are decoded
    assign w_unused_ok = ^{s_sel_i, s_adr_i[31:4]};

    assign w_req     = s_cyc_i & s_stb_i & ~r_s_ack;
    assign w_wr      = w_req & s_we_i;
    assign w_rd      = w_req & ~s_we_i;
    assign w_idx     = s_adr_i[3:0];
    assign w_push    = w_wr & (w_idx == 4'd7);
    assign w_flush   = w_wr & (w_idx == 4'd8);
    assign w_stat_wr = w_wr & (w_idx == 4'd0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A same-cycle pop frees the head slot, so a PUSH while full still lands
    assign w_push_ok = w_push & (~w_full | w_pop);

    assign s_ack_o = r_s_ack;
    assign s_dat_o = r_s_dat;
    assign m_cyc_o = r_m_cyc;
    assign m_stb_o = r_m_stb;
    assign m_we_o  = r_m_we;
    assign m_sel_o = r_m_sel;
    assign m_adr_o = r_m_adr;
    assign m_dat_o = r_m_dat;
    assign busy    = r_busy;

`ifdef GPU_BLITQ_IRQ_EN
    logic r_irq;

    // Drain interrupt: last queued command finished; cleared by any STATUS write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if ((r_state == S_DONE) && !blit_busy && w_empty) begin
            r_irq <= 1'b1;
        end else if (w_stat_wr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // FIFO occupancy after this cycle's push/pop/flush
    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Slave register read mux
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            4'd0: w_rdata = {16'h0, 8'(r_count), 4'h0, irq, r_ovf, w_full, w_empty};
            4'd1: w_rdata = {29'h0, (r_state == S_IDLE), blit_busy, r_busy};
            4'd2: w_rdata = r_stg_x;
            4'd3: w_rdata = r_stg_y;
            4'd4: w_rdata = r_stg_w;
            4'd5: w_rdata = r_stg_h;
            4'd6: w_rdata = r_stg_pat;
            default: w_rdata = '0;
        endcase
    end

    // Blitter register value for the current write index
    always_comb begin
        w_wdata = '0;
        case (r_widx)
            3'd2: w_wdata = r_cur.x;
            3'd3: w_wdata = r_cur.y;
            3'd4: w_wdata = r_cur.w;
            3'd5: w_wdata = r_cur.h;
            3'd6: w_wdata = r_cur.pat;
            default: w_wdata = {29'h0, r_cur.clip, r_cur.fill, 1'b1};
        endcase
    end

    // Slave port: single-cycle registered ack, never stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ack <= 1'b0;
            r_s_dat <= '0;
        end else begin
            r_s_ack <= w_req;
            r_s_dat <= w_rd ? w_rdata : '0;
        end
    end

    // Staging registers and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_x   <= '0;
            r_stg_y   <= '0;
            r_stg_w   <= '0;
            r_stg_h   <= '0;
            r_stg_pat <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    4'd2: r_stg_x   <= s_dat_i;
                    4'd3: r_stg_y   <= s_dat_i;
                    4'd4: r_stg_w   <= s_dat_i;
                    4'd5: r_stg_h   <= s_dat_i;
                    4'd6: r_stg_pat <= s_dat_i;
                    default: ;
                endcase
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= '{clip: s_dat_i[2], fill: s_dat_i[1], pat: r_stg_pat,
                                  h: r_stg_h, w: r_stg_w, y: r_stg_y, x: r_stg_x};
        end
    end

    // FIFO pointers, count and in-flight command capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cur    <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_pop) begin
                r_cur <= r_fifo[r_rd_ptr];
            end
        end
    end

    // Sequencer state register and registered master outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_widx  <= '0;
            r_m_cyc <= 1'b0;
            r_m_stb <= 1'b0;
            r_m_we  <= 1'b0;
            r_m_sel <= '0;
            r_m_adr <= '0;
            r_m_dat <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_widx  <= w_widx_nxt;
            r_m_cyc <= w_m_cyc_nxt;
            r_m_stb <= w_m_stb_nxt;
            r_m_we  <= w_m_we_nxt;
            r_m_sel <= w_m_sel_nxt;
            r_m_adr <= w_m_adr_nxt;
            r_m_dat <= w_m_dat_nxt;
            r_busy  <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
        end
    end

    // Sequencer next-state: X, Y, W, H, PATTERN then CTRL with START
    always_comb begin
        w_state_nxt = r_state;
        w_widx_nxt  = r_widx;
        w_pop       = 1'b0;
        w_m_cyc_nxt = r_m_cyc;
        w_m_stb_nxt = r_m_stb;
        w_m_we_nxt  = r_m_we;
        w_m_sel_nxt = r_m_sel;
        w_m_adr_nxt = r_m_adr;
        w_m_dat_nxt = r_m_dat;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !blit_busy) begin
                    w_pop       = 1'b1;
                    w_widx_nxt  = 3'd2;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_m_cyc_nxt = 1'b1;
                w_m_stb_nxt = 1'b1;
                w_m_we_nxt  = 1'b1;
                w_m_sel_nxt = 4'hF;
                w_m_adr_nxt = {BLIT_BASE[31:4], 1'b0, r_widx};
                w_m_dat_nxt = w_wdata;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (m_ack_i) begin
                    w_m_cyc_nxt = 1'b0;
                    w_m_stb_nxt = 1'b0;
                    w_m_we_nxt  = 1'b0;
                    w_m_sel_nxt = '0;
                    w_m_adr_nxt = '0;
                    w_m_dat_nxt = '0;
                    case (r_widx)
                        3'd0: w_state_nxt = S_DONE;
                        3'd6: begin
                            w_widx_nxt  = 3'd0;
                            w_state_nxt = S_WRITE;
                        end
                        default: begin
                            w_widx_nxt  = r_widx + 3'd1;
                            w_state_nxt = S_WRITE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (!blit_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpu_blit_queue.sv
// Directed bench for gpu_blit_queue with a simple blitter slave model.
module tb_gpu_blit_queue;

    localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef GPU_BLITQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [3:0]  s_sel_i = 4'hF;
    logic [31:0] s_adr_i = '0, s_dat_i = '0;
    logic        s_ack_o;
    logic [31:0] s_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i = 1'b0;
    wire         blit_busy;
    logic        busy, irq;

    int n_cmp = 0;
    int n_err = 0;

    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];

    logic        p_stb = 1'b0, p_ack = 1'b0;
    logic [31:0] p_adr = '0, p_dat = '0;
    int          viol = 0;

    gpu_blit_queue dut (
        .clk(clk), .rst(rst),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i),
        .blit_busy(blit_busy), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    assign blit_busy = force_busy | (busy_cnt != 0);

    // Blitter slave model: registered ack after ack_delay cycles; START raises busy
    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (rst) begin
            m_ack_i <= 1'b0;
            ack_cnt <= 0;
        end else if (m_ack_i) begin
            m_ack_i <= 1'b0;
        end else if (m_cyc_o && m_stb_o) begin
            if (ack_cnt >= ack_delay) begin
                m_ack_i <= 1'b1;
                ack_cnt <= 0;
                log_adr.push_back(m_adr_o);
                log_dat.push_back(m_dat_o);
                if (m_adr_o[3:0] == 4'd0 && m_dat_o[0]) busy_cnt <= 4;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    // Master stability monitor: an unacked strobe must hold address and data
    always @(posedge clk) begin
        if (!rst && p_stb && !p_ack &&
            (!m_stb_o || m_adr_o != p_adr || m_dat_o != p_dat)) viol <= viol + 1;
        p_stb <= m_stb_o;
        p_ack <= m_ack_i;
        p_adr <= m_adr_o;
        p_dat <= m_dat_o;
    end

    task automatic wb_write(input logic [3:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
        s_adr_i = {28'h0, idx}; s_dat_i = d;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (s_ack_o) break;
        end
        if (!s_ack_o) begin
            n_cmp++; n_err++;
            $display("FAIL wb_write_ack idx=%0d: no ack within 10 cycles", idx);
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] idx, output logic [31:0] d);
        @(posedge clk); #1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = {28'h0, idx};
        d = 'x;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (s_ack_o) begin
                d = s_dat_o;
                break;
            end
        end
        if (!s_ack_o) begin
            n_cmp++; n_err++;
            $display("FAIL wb_read_ack idx=%0d: no ack within 10 cycles", idx);
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (log_adr.size() >= n) break;
            @(posedge clk); #1;
        end
        if (log_adr.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL wait_log: got %0d master writes, required %0d", log_adr.size(), n);
        end
    endtask

    task automatic wait_busy_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL wait_busy_low: busy still 1 after %0d cycles", budget);
        end
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, busy, irq} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: m_cyc=%b m_adr=%h s_ack=%b busy=%b irq=%b, required all 0",
                     m_cyc_o, m_adr_o, s_ack_o, busy, irq);
        end
        rst = 1'b0;
        wb_read(4'd0, d);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_err++; $display("FAIL reset_status: got %h, required 00000001", d);
        end
        wb_read(4'd1, d);
        n_cmp++;
        if (d !== 32'h0000_0004) begin
            n_err++; $display("FAIL reset_engine: got %h, required 00000004", d);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [31:0] exp_adr[6];
        logic [31:0] exp_dat[6];
        exp_adr = '{BASE + 32'd2, BASE + 32'd3, BASE + 32'd4, BASE + 32'd5, BASE + 32'd6, BASE};
        exp_dat = '{32'd8, 32'd16, 32'd64, 32'd2, 32'hFFFF_FFFF, 32'd7};
        clear_log();
        wb_write(4'd2, 32'd8);
        wb_write(4'd3, 32'd16);
        wb_write(4'd4, 32'd64);
        wb_write(4'd5, 32'd2);
        wb_write(4'd6, 32'hFFFF_FFFF);
        wb_read(4'd4, d);
        n_cmp++;
        if (d !== 32'd64) begin
            n_err++; $display("FAIL staging_readback: got %h, required 00000040", d);
        end
        wb_read(4'd7, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++; $display("FAIL push_read: got %h, required 00000000", d);
        end
        wb_read(4'd15, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++; $display("FAIL unmapped_read: got %h, required 00000000", d);
        end
        wb_write(4'd7, 32'h6);
        wait_log(6, 200);
        n_cmp++;
        if (busy !== 1'b1 || blit_busy !== 1'b1) begin
            n_err++; $display("FAIL single_busy_after_start: busy=%b blit_busy=%b, required 1 1", busy, blit_busy);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_adr.size() <= i || log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) begin
                n_err++;
                if (log_adr.size() > i)
                    $display("FAIL single_write%0d: adr=%h dat=%h, required adr=%h dat=%h",
                             i, log_adr[i], log_dat[i], exp_adr[i], exp_dat[i]);
                else
                    $display("FAIL single_write%0d: missing, required adr=%h", i, exp_adr[i]);
            end
        end
        wait_busy_low(50);
        n_cmp++;
        if (blit_busy !== 1'b0) begin
            n_err++; $display("FAIL single_busy_order: busy fell while blit_busy=%b, required 0", blit_busy);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        clear_log();
        wb_write(4'd0, 32'h0);
        force_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb_write(4'd2, 32'd100 + 32'(k));
            wb_write(4'd7, 32'h0);
        end
        repeat (5) @(posedge clk);
        #1;
        wb_read(4'd0, d);
        n_cmp++;
        if (d !== 32'h0000_0406) begin
            n_err++; $display("FAIL ovf_status: got %h, required 00000406", d);
        end
        n_cmp++;
        if (log_adr.size() != 0) begin
            n_err++; $display("FAIL ovf_no_master: %0d writes issued while blit_busy, required 0", log_adr.size());
        end
        force_busy = 1'b0;
        wait_log(24, 600);
        wait_busy_low(100);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (log_adr.size() != 24) begin
            n_err++; $display("FAIL ovf_cmd_count: %0d writes, required 24", log_adr.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (log_adr.size() < 6 * k + 6 || log_dat[6*k] !== 32'd100 + 32'(k) ||
                log_dat[6*k+1] !== 32'd16 || log_adr[6*k+5] !== BASE || log_dat[6*k+5] !== 32'd1) begin
                n_err++;
                $display("FAIL ovf_cmd%0d: x/y/ctrl wrong or missing, required x=%0d y=16 ctrl=1", k, 100 + k);
            end
        end
        wb_write(4'd0, 32'h0);
        wb_read(4'd0, d);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_err++; $display("FAIL ovf_clear: got %h, required 00000001", d);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        clear_log();
        force_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wb_write(4'd2, 32'd200 + 32'(k));
            wb_write(4'd7, 32'h2);
        end
        force_busy = 1'b0;
        wait_log(1, 100);
        wb_write(4'd8, 32'h0);
        wait_busy_low(200);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (log_adr.size() != 6) begin
            n_err++; $display("FAIL flush_count: %0d writes, required 6", log_adr.size());
        end
        n_cmp++;
        if (log_adr.size() < 6 || log_dat[0] !== 32'd200 || log_adr[5] !== BASE || log_dat[5] !== 32'd3) begin
            n_err++; $display("FAIL flush_inflight: first command incomplete, required x=200 ctrl=3");
        end
        wb_read(4'd0, d);
        n_cmp++;
        if (d !== {28'h0, IRQ_ON, 3'b001}) begin
            n_err++; $display("FAIL flush_status: got %h, required %h", d, {28'h0, IRQ_ON, 3'b001});
        end
    endtask

    task automatic test_slow_ack();
        int v0;
        logic [3:0] exp_idx[6];
        exp_idx = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
        clear_log();
        v0 = viol;
        ack_delay = 5;
        wb_write(4'd2, 32'd9);
        wb_write(4'd7, 32'h4);
        wait_log(6, 300);
        wait_busy_low(100);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (log_adr.size() != 6) begin
            n_err++; $display("FAIL slow_count: %0d writes, required 6", log_adr.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_adr.size() <= i || log_adr[i][3:0] !== exp_idx[i]) begin
                n_err++; $display("FAIL slow_idx%0d: wrong or missing index, required %0d", i, exp_idx[i]);
            end
        end
        n_cmp++;
        if (log_dat.size() < 6 || log_dat[0] !== 32'd9 || log_dat[5] !== 32'd5) begin
            n_err++; $display("FAIL slow_data: x/ctrl wrong, required x=9 ctrl=5");
        end
        n_cmp++;
        if (viol != v0) begin
            n_err++; $display("FAIL slow_stb_stable: %0d unstable strobe cycles, required 0", viol - v0);
        end
        ack_delay = 0;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        clear_log();
        wb_write(4'd0, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_clear_start: got %b, required 0", irq);
        end
        force_busy = 1'b1;
        wb_write(4'd7, 32'h0);
        wb_write(4'd7, 32'h0);
        force_busy = 1'b0;
        wait_log(7, 200);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_after_first: got %b, required 0", irq);
        end
        wait_busy_low(200);
        n_cmp++;
        if (irq !== IRQ_ON) begin
            n_err++; $display("FAIL irq_after_drain: got %b, required %b", irq, IRQ_ON);
        end
        wb_read(4'd0, d);
        n_cmp++;
        if (d !== {28'h0, IRQ_ON, 3'b001}) begin
            n_err++; $display("FAIL irq_status: got %h, required %h", d, {28'h0, IRQ_ON, 3'b001});
        end
        wb_write(4'd0, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_status_write_clear: got %b, required 0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_flush();
        test_slow_ack();
        test_irq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
